// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   MD_WIDTH        default operand / HI / LO width
//   MD_MULT..MD_DIVU MDOp encodings
//   md_state_t      multiply/divide FSM states
//   mdIsDiv / mdIsSigned  decode helpers for MDOp
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  // Bit 1 of MDOp selects divide, bit 0 selects the unsigned variant.
  function automatic logic mdIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic mdIsSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   isDiv    in   1      1: restoring-divide step, 0: shift-add multiply step
//   accHi    in   WIDTH  upper accumulator half (partial product / remainder)
//   accLo    in   WIDTH  lower accumulator half (multiplier bits / dividend+quotient bits)
//   operand  in   WIDTH  multiplicand or divisor magnitude
//   nextHi   out  WIDTH  accumulator upper half after this iteration
//   nextLo   out  WIDTH  accumulator lower half after this iteration
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Multiply: add the multiplicand when the current multiplier bit (LSB of
  // accLo) is set, then shift the whole {carry, accHi, accLo} right by one.
  assign sum = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});

  // Divide: shift the next dividend bit into the remainder. The shifted value
  // can need WIDTH+1 bits, but whenever the subtraction succeeds the result
  // is below the divisor, so WIDTH bits of the difference are enough.
  assign shifted = {accHi, accLo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, operand});
  assign trial   = shifted[WIDTH-1:0] - operand;

  always_comb begin
    nextHi = accHi;
    nextLo = accLo;
    if (isDiv) begin
      if (fits) begin
        nextHi = trial;
        nextLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = shifted[WIDTH-1:0];
        nextLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextHi = sum[WIDTH:1];
      nextLo = {sum[0], accLo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Serves MULT/MULTU/DIV/DIVU (WIDTH iterations plus one sign-fix cycle) and
// MTHI/MTLO (single-cycle register moves while idle).
// Ports:
//   clk      in   1      clock, rising edge
//   reset    in   1      synchronous, active-high; aborts any operation
//   Start    in   1      begin operation MDOp (accepted only while idle)
//   MDOp     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA     in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//   SrcB     in   WIDTH  multiplier / divisor
//   MTHI     in   1      HI <= SrcA (idle only)
//   MTLO     in   1      LO <= SrcA (idle only)
//   Busy     out  1      high while an operation is in flight
//   Done     out  1      one-cycle pulse when new HI/LO first become visible
//   DivZero  out  1      qualified by Done: divide had a zero divisor
//   HI       out  WIDTH  HI register
//   LO       out  WIDTH  LO register
//
// Handshake: Start/MTHI/MTLO act as valid and ~Busy as ready. A request is
// taken on a rising edge where it is high and Busy is low; anything presented
// while Busy is high is dropped, not queued. Start has priority over moves in
// the same cycle. The internal `state` signal is the FSM state for probing.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             MTHI,
  input  logic             MTLO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_t state;
  md_state_t nextState;

  logic [CNT_W-1:0] count;
  logic             opDiv;
  logic             negQ;
  logic             negR;
  logic             bZero;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] operand;

  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] productNeg;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  // Operand magnitudes; unsigned ops pass the raw values through.
  assign aNeg = mdIsSigned(MDOp) & SrcA[WIDTH-1];
  assign bNeg = mdIsSigned(MDOp) & SrcB[WIDTH-1];
  assign absA = aNeg ? -SrcA : SrcA;
  assign absB = bNeg ? -SrcB : SrcB;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .isDiv   (opDiv),
    .accHi   (accHi),
    .accLo   (accLo),
    .operand (operand),
    .nextHi  (stepHi),
    .nextLo  (stepLo)
  );

  // Sign correction applied in FIX. With a zero divisor the restoring loop
  // yields quotient = all ones and remainder = |A|; the quotient is left
  // unfixed, and re-applying A's sign to the remainder restores raw SrcA.
  assign product    = {accHi, accLo};
  assign productNeg = -product;

  always_comb begin
    fixHi = accHi;
    fixLo = accLo;
    if (opDiv) begin
      fixLo = (negQ && !bZero) ? -accLo : accLo;
      fixHi = negR ? -accHi : accHi;
    end else if (negQ) begin
      {fixHi, fixLo} = productNeg;
    end
  end

  // FSM: next-state logic
  always_comb begin
    nextState = state;
    case (state)
      MD_IDLE: if (Start) nextState = MD_RUN;
      MD_RUN:  if (count == LAST_ITER) nextState = MD_FIX;
      MD_FIX:  nextState = MD_IDLE;
      default: nextState = MD_IDLE;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
    end else begin
      state <= nextState;
    end
  end

  assign Busy = (state != MD_IDLE);

  // Datapath, operand latches and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      opDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      bZero   <= 1'b0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (Start) begin
            count <= '0;
            opDiv <= mdIsDiv(MDOp);
            negQ  <= aNeg ^ bNeg;
            negR  <= aNeg;
            bZero <= (SrcB == '0);
            accHi <= '0;
            // Divide shifts the dividend out of accLo; multiply consumes
            // multiplier bits from accLo.
            if (mdIsDiv(MDOp)) begin
              accLo   <= absA;
              operand <= absB;
            end else begin
              accLo   <= absB;
              operand <= absA;
            end
          end else begin
            if (MTHI) HI <= SrcA;
            if (MTLO) LO <= SrcA;
          end
        end
        MD_RUN: begin
          accHi <= stepHi;
          accLo <= stepLo;
          count <= (count == LAST_ITER) ? '0 : count + 1'b1;
        end
        MD_FIX: begin
          HI      <= fixHi;
          LO      <= fixLo;
          Done    <= 1'b1;
          DivZero <= opDiv & bZero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors with hand-computed results,
// an arithmetic reference model and a per-cycle compare process.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   MDOp  = 2'b00;
  logic [W-1:0] SrcA  = '0;
  logic [W-1:0] SrcB  = '0;
  logic         MTHI  = 1'b0;
  logic         MTLO  = 1'b0;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .MTHI    (MTHI),
    .MTLO    (MTLO),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .HI      (HI),
    .LO      (LO)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result of one operation computed with plain 64-bit arithmetic.
  function automatic void model_calc(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] hi,
                                     output logic [W-1:0] lo, output logic dz);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == MD_MULT) begin
      p = sa * sb;
      u = p;
      {hi, lo} = u;
    end else if (op == MD_MULTU) begin
      u = {32'b0, a} * {32'b0, b};
      {hi, lo} = u;
    end else if (b == '0) begin
      lo = '1;
      hi = a;
      dz = 1'b1;
    end else if (op == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
      u = q;
      lo = u[31:0];
      u = r;
      hi = u[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Expected architectural state, advanced once per rising edge.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int           m_rem = 0;   // edges left until the pending result lands

  // Compare process: 1 time unit after each rising edge, update the model
  // from the (still stable) inputs, then compare every output.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_rem = 0;
      end else begin
        m_done = 1'b0;
        m_dz   = 1'b0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
          end
        end else if (Start) begin
          model_calc(MDOp, SrcA, SrcB, p_hi, p_lo, p_dz);
          m_rem = W + 1;
        end else begin
          if (MTHI) m_hi = SrcA;
          if (MTLO) m_lo = SrcA;
        end
      end
      check("cyc_busy", {31'b0, Busy}, {31'b0, (m_rem != 0)});
      check("cyc_done", {31'b0, Done}, {31'b0, m_done});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
      if (m_done) check("cyc_divzero", {31'b0, DivZero}, {31'b0, m_dz});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic mthi, input logic mtlo);
    @(negedge clk);
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b; MTHI = mthi; MTLO = mtlo;
    @(negedge clk);
    Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
  endtask

  // Called on the first falling edge after the Start edge (lat = 0 there).
  task automatic wait_done(output int lat, output int busyc);
    lat = 0;
    busyc = 0;
    while (Done !== 1'b1 && lat < 100) begin
      if (Busy) busyc++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (Done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: no Done within %0d cycles", lat);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, busyc;
    start_op(op, a, b, 1'b0, 1'b0);
    wait_done(lat, busyc);
  endtask

  task automatic move(input logic [W-1:0] a, input logic mthi, input logic mtlo);
    @(negedge clk);
    SrcA = a; MTHI = mthi; MTLO = mtlo;
    @(negedge clk);
    MTHI = 1'b0; MTLO = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, busyc, done_seen;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;

    // MTHI and MTLO together both write
    move(32'd18, 1'b1, 1'b1);
    check("mt_both_hi", HI, 32'd18);
    check("mt_both_lo", LO, 32'd18);

    // MULT 5 x -53 with latency / Busy length / Done width
    start_op(MD_MULT, 32'd5, 32'hFFFF_FFCB, 1'b0, 1'b0);
    check("mult_old_hi", HI, 32'd18);
    wait_done(lat, busyc);
    check("mult_latency", lat, 32'd33);
    check("mult_busy_len", busyc, 32'd33);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FEF7);
    @(negedge clk);
    check("mult_done_pulse", {31'b0, Done}, 32'd0);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    run_op(MD_DIV, 32'd123987, 32'hFFFF_FFCB);
    check("div1_lo", LO, 32'hFFFF_F6DD);
    check("div1_hi", HI, 32'h0000_0014);

    run_op(MD_DIV, 32'hFFFF_FFCB, 32'd5);
    check("div2_lo", LO, 32'hFFFF_FFF6);
    check("div2_hi", HI, 32'hFFFF_FFFD);

    start_op(MD_DIVU, 32'd654, 32'd0, 1'b0, 1'b0);
    wait_done(lat, busyc);
    check("divu0_dz", {31'b0, DivZero}, 32'd1);
    check("divu0_lo", LO, 32'hFFFF_FFFF);
    check("divu0_hi", HI, 32'd654);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'h0000_0000);

    // Extra vectors checked by the model each cycle
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE);   // -7 / -2 -> q 3, r -1
    check("div3_lo", LO, 32'd3);
    check("div3_hi", HI, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd1);
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'd100, 32'd7);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);           // signed divide by zero
    check("div0_hi", HI, 32'hFFFF_FFF9);
    check("div0_lo", LO, 32'hFFFF_FFFF);

    // Reset in the middle of RUN: aborted, nothing written, no Done
    start_op(MD_MULTU, 32'd1000, 32'd1000, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

    // MTHI/MTLO while Busy are ignored
    start_op(MD_MULT, 32'd7, 32'd6, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    SrcA = 32'h1234; MTHI = 1'b1; MTLO = 1'b1;
    @(negedge clk);
    MTHI = 1'b0; MTLO = 1'b0;
    check("busy_mt_hi", HI, 32'd0);
    wait_done(lat, busyc);
    check("busy_mt_res_hi", HI, 32'd0);
    check("busy_mt_res_lo", LO, 32'd42);

    // Start with MTHI/MTLO in idle: moves are dropped
    start_op(MD_MULTU, 32'd3, 32'd4, 1'b1, 1'b1);
    check("start_mt_hi", HI, 32'd0);
    check("start_mt_lo", LO, 32'd42);
    wait_done(lat, busyc);
    check("start_mt_res_lo", LO, 32'd12);
    check("start_mt_res_hi", HI, 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
